// File: rtl/shadow_key_schedule.sv
// Shadow-32 round-key generator: loads a 64-bit master key, emits one round key per step.
// Optional reverse (decryption) order with precompute buffer: define SHADOW_KS_DEC_EN.
module shadow_key_schedule #(
   parameter int NUM_ROUNDS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] key_in,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic        dec,
   input  logic        step,
   output logic [63:0] r_keys,
   output logic [5:0]  round,
   output logic        rk_valid,
   output logic        last_round,
   output logic        done
);

   localparam logic [5:0] LAST = 6'(NUM_ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, PRE, RUN, DONE} state_e;

   function automatic logic [63:0] ks_update(input logic [63:0] k, input logic [5:0] rc);
      return {k[55:0], k[63:56]} ^ ({k[62:0], k[63]} & {k[56:0], k[63:57]}) ^ {58'b0, rc};
   endfunction

   state_e      state_q;
   logic [63:0] key_q, key_d;
   logic [5:0]  round_q;
   logic [5:0]  rc_q, rc_d;
   logic        rk_valid_q;
   logic        done_q;

   assign key_d = ks_update(key_q, rc_q);
   assign rc_d  = {rc_q[4:0], rc_q[5] ^ rc_q[4]};

`ifdef SHADOW_KS_DEC_EN
   localparam int AW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

   logic        dec_q;
   logic [5:0]  ptr_q;
   logic [5:0]  rd_idx;
   logic [63:0] kbuf_q [NUM_ROUNDS];

   assign rd_idx     = round_q - 6'd1;
   assign last_round = rk_valid_q && (dec_q ? (round_q == 6'd0) : (round_q == LAST));

   // Keys 0..NUM_ROUNDS-2 are captured while PRE walks the schedule forward.
   always_ff @(posedge clk) begin
      if (state_q == PRE) kbuf_q[ptr_q[AW-1:0]] <= key_q;
   end
`else
   logic unused_dec;
   assign unused_dec = dec;
   assign last_round = rk_valid_q && (round_q == LAST);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         key_q      <= '0;
         round_q    <= '0;
         rc_q       <= '0;
         rk_valid_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef SHADOW_KS_DEC_EN
         dec_q      <= 1'b0;
         ptr_q      <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (key_valid) begin
                  key_q   <= key_in;
                  rc_q    <= 6'd1;
                  round_q <= '0;
`ifdef SHADOW_KS_DEC_EN
                  ptr_q   <= '0;
                  dec_q   <= dec;
                  if (dec) begin
                     state_q    <= PRE;
                     rk_valid_q <= 1'b0;
                  end else begin
                     state_q    <= RUN;
                     rk_valid_q <= 1'b1;
                  end
`else
                  state_q    <= RUN;
                  rk_valid_q <= 1'b1;
`endif
               end
            end
`ifdef SHADOW_KS_DEC_EN
            PRE: begin
               key_q <= key_d;
               rc_q  <= rc_d;
               ptr_q <= ptr_q + 6'd1;
               if (ptr_q == LAST - 6'd1) begin
                  state_q    <= RUN;
                  rk_valid_q <= 1'b1;
                  round_q    <= LAST;
               end
            end
`endif
            RUN: begin
               if (step) begin
                  if (last_round) begin
                     state_q    <= DONE;
                     rk_valid_q <= 1'b0;
                     done_q     <= 1'b1;
`ifdef SHADOW_KS_DEC_EN
                  end else if (dec_q) begin
                     round_q <= rd_idx;
                     key_q   <= kbuf_q[rd_idx[AW-1:0]];
`endif
                  end else begin
                     key_q   <= key_d;
                     rc_q    <= rc_d;
                     round_q <= round_q + 6'd1;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign key_ready = (state_q == IDLE);
   assign r_keys    = key_q;
   assign round     = round_q;
   assign rk_valid  = rk_valid_q;
   assign done      = done_q;

endmodule

// File: tb/tb_shadow_key_schedule.sv
// Directed bench for shadow_key_schedule: key-table model plus literal spot checks.
module tb_shadow_key_schedule;

   localparam int NR = 32;

   typedef bit [63:0] karr_t [64];

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] key_in = '0;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic        dec = 1'b0;
   logic        step = 1'b0;
   logic [63:0] r_keys;
   logic [5:0]  round;
   logic        rk_valid;
   logic        last_round;
   logic        done;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   shadow_key_schedule #(.NUM_ROUNDS(NR)) dut (
      .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
      .key_ready(key_ready), .dec(dec), .step(step), .r_keys(r_keys),
      .round(round), .rk_valid(rk_valid), .last_round(last_round), .done(done)
   );

   always #5 clk = ~clk;

   function automatic bit [63:0] rotl(bit [63:0] k, int n);
      return (k << n) | (k >> (64 - n));
   endfunction

   function automatic karr_t gen_keys(bit [63:0] k0);
      karr_t r;
      bit [63:0] k = k0;
      bit [5:0] rc = 6'd1;
      for (int i = 0; i < 64; i++) begin
         r[i] = k;
         k  = rotl(k, 8) ^ (rotl(k, 1) & rotl(k, 7)) ^ {58'b0, rc};
         rc = {rc[4:0], rc[5] ^ rc[4]};
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 precompute, 2 keys presented, 3 done pulse.
   int    m_ph, m_idx, m_pre;
   bit    m_dec;
   karr_t m_keys;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph  <= 0;
         m_idx <= 0;
         m_dec <= 1'b0;
      end else begin
         case (m_ph)
            0: if (key_valid) begin
               m_keys <= gen_keys(key_in);
`ifdef SHADOW_KS_DEC_EN
               m_dec <= dec;
               if (dec) begin m_ph <= 1; m_pre <= NR - 1; end
               else begin m_ph <= 2; m_idx <= 0; end
`else
               m_dec <= 1'b0;
               m_ph  <= 2;
               m_idx <= 0;
`endif
            end
            1: begin
               m_pre <= m_pre - 1;
               if (m_pre == 1) begin m_ph <= 2; m_idx <= NR - 1; end
            end
            2: if (step) begin
               if (m_idx == (m_dec ? 0 : NR - 1)) m_ph <= 3;
               else m_idx <= m_dec ? m_idx - 1 : m_idx + 1;
            end
            default: m_ph <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         chk("key_ready", key_ready, m_ph == 0);
         chk("rk_valid", rk_valid, m_ph == 2);
         chk("done", done, m_ph == 3);
         if (m_ph == 2) begin
            chk("round", round, m_idx);
            chk("r_keys", r_keys, m_keys[m_idx]);
            chk("last_round", last_round, m_idx == (m_dec ? 0 : NR - 1));
         end else begin
            chk("last_round_idle", last_round, 0);
         end
      end
   end

   task automatic handshake(input bit [63:0] k, input bit d);
      key_valid = 1'b1; key_in = k; dec = d;
      @(posedge clk); #2;
      key_valid = 1'b0; dec = 1'b0;
   endtask

   task automatic do_step();
      step = 1'b1;
      @(posedge clk); #2;
      step = 1'b0;
   endtask

   task automatic run_to_done(input bit gaps);
      bit ok = 1'b0;
      for (int n = 0; n < 400 && !ok; n++) begin
         if (gaps) repeat (n % 6) begin @(posedge clk); #2; end
         do_step();
         if (done) ok = 1'b1;
      end
      chk("run_to_done_timeout", ok, 1'b1);
   endtask

   initial begin
      karr_t ref_k;
      int lr_cnt, lr_rnd, dn_cnt, v_cnt, cyc;
      bit [63:0] ka = 64'h0123456789ABCDEF;
      bit [63:0] kb = 64'hFEDCBA9876543210;

      #12;
      chk("rst_key_ready", key_ready, 1'b1);
      chk("rst_rk_valid", rk_valid, 1'b0);
      chk("rst_r_keys", r_keys, 64'h0);
      chk("rst_round", round, 6'd0);
      chk("rst_done", done, 1'b0);
      chk("rst_last", last_round, 1'b0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #2;

      // Zero key: hand-computed first keys
      handshake(64'h0, 1'b0);
      @(negedge clk);
      chk("k0_key", r_keys, 64'h0);
      chk("k0_round", round, 6'd0);
      @(posedge clk); #2;
      do_step();
      @(negedge clk);
      chk("k1_key", r_keys, 64'h1);
      chk("k1_round", round, 6'd1);
      @(posedge clk); #2;
      do_step();
      @(negedge clk);
      chk("k2_key", r_keys, 64'h102);
      chk("k2_round", round, 6'd2);
      @(posedge clk); #2;
      run_to_done(1'b0);
      @(posedge clk); #2;

      // Step held high through a whole sequence
      handshake(ka, 1'b0);
      @(negedge clk);
      chk("ka_key0", r_keys, ka);
      step = 1'b1;
      lr_cnt = 0; lr_rnd = -1; dn_cnt = 0; v_cnt = 1;
      for (cyc = 0; cyc < 100; cyc++) begin
         @(negedge clk);
         if (rk_valid) v_cnt++;
         if (last_round) begin lr_cnt++; lr_rnd = round; end
         if (done) begin dn_cnt++; break; end
      end
      chk("held_done_seen", dn_cnt, 1);
      chk("held_keyready_at_done", key_ready, 1'b0);
      chk("held_valid_cycles", v_cnt, NR);
      chk("held_last_cnt", lr_cnt, 1);
      chk("held_last_round", lr_rnd, 31);
      @(negedge clk);
      chk("held_keyready_after", key_ready, 1'b1);
      chk("held_done_once", done, 1'b0);
      step = 1'b0;
      @(posedge clk); #2;

      // Irregular gaps, then steps while idle must be ignored
      handshake(kb, 1'b0);
      run_to_done(1'b1);
      @(posedge clk); #2;
      do_step();
      do_step();
      @(negedge clk);
      ref_k = gen_keys(kb);
      chk("idle_step_key", r_keys, ref_k[NR-1]);
      chk("idle_step_round", round, 6'd31);
      chk("idle_step_valid", rk_valid, 1'b0);
      @(posedge clk); #2;

      // key_valid pulsed mid-run is ignored
      handshake(ka, 1'b0);
      repeat (5) do_step();
      key_valid = 1'b1; key_in = kb;
      @(posedge clk); #2;
      key_valid = 1'b0;
      @(negedge clk);
      ref_k = gen_keys(ka);
      chk("midrun_kv_key", r_keys, ref_k[5]);
      @(posedge clk); #2;
      run_to_done(1'b0);
      @(posedge clk); #2;

      // Asynchronous reset at round 17
      handshake(kb, 1'b0);
      repeat (17) do_step();
      @(negedge clk);
      chk("pre_rst_round", round, 6'd17);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_key_ready", key_ready, 1'b1);
      chk("midrst_r_keys", r_keys, 64'h0);
      chk("midrst_round", round, 6'd0);
      chk("midrst_rk_valid", rk_valid, 1'b0);
      chk("midrst_last", last_round, 1'b0);
      #1 rst_n = 1'b1;
      @(posedge clk); #2;
      handshake(ka, 1'b0);
      @(negedge clk);
      chk("reload_round", round, 6'd0);
      chk("reload_key", r_keys, ka);
      @(posedge clk); #2;
      run_to_done(1'b1);
      @(posedge clk); #2;

`ifdef SHADOW_KS_DEC_EN
      // Reverse order
      handshake(ka, 1'b1);
      cyc = 0;
      while (cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (rk_valid) break;
      end
      chk("dec_latency", cyc, NR);
      chk("dec_first_round", round, 6'd31);
      ref_k = gen_keys(ka);
      chk("dec_first_key", r_keys, ref_k[NR-1]);
      @(posedge clk); #2;
      step = 1'b1;
      lr_rnd = -1;
      for (cyc = 0; cyc < 100; cyc++) begin
         @(negedge clk);
         if (last_round) lr_rnd = round;
         if (done) break;
      end
      step = 1'b0;
      chk("dec_last_round", lr_rnd, 0);
      @(posedge clk); #2;
      handshake(kb, 1'b1);
      repeat (NR + 3) begin @(posedge clk); #2; end
      run_to_done(1'b1);
      @(posedge clk); #2;
`endif

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
